// File: rtl/ras_spec_unit.sv
// ras_spec_unit: speculative return-address stack with checkpoint repair from branch feedback.
module ras_spec_unit #(
    parameter int DEPTH = 8,
    parameter int PW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pred_push_i,
    input  logic          pred_pop_i,
    input  logic [29:0]   pred_ret_addr_i,
    output logic [29:0]   ras_top_o,
    output logic [PW-1:0] ras_ptr_o,
    output logic [PW-1:0] ras_cnt_o,
    output logic          ras_valid_o,
    input  logic          upd_valid_i,
    input  logic          upd_flush_i,
    input  logic [1:0]    upd_br_type_i,
    input  logic [29:0]   upd_pc_i,
    input  logic [PW-1:0] upd_ptr_i,
    input  logic [PW-1:0] upd_cnt_i
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [1:0] BR_PC_RELATIVE = 2'b00;
    localparam logic [1:0] BR_ABSOLUTE    = 2'b01;
    localparam logic [1:0] BR_CALL        = 2'b10;
    localparam logic [1:0] BR_RETURN      = 2'b11;
    localparam logic [PW-1:0] FULL = PW'(DEPTH);

    logic [29:0]   mem_q [DEPTH];
    logic [IW-1:0] ptr_q, ptr_d, wr_idx;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [29:0]   wr_data;
    logic          wr_en;
    logic [IW-1:0] up;
    logic          repair;

    assign up     = upd_ptr_i[IW-1:0];
    assign repair = upd_valid_i & upd_flush_i;

    always_comb begin
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_idx  = ptr_q + 1'b1;
        wr_data = pred_ret_addr_i;
        if (repair) begin
            if (upd_br_type_i == BR_CALL) begin
                ptr_d   = up + 1'b1;
                cnt_d   = (upd_cnt_i >= FULL) ? FULL : upd_cnt_i + 1'b1;
                wr_en   = 1'b1;
                wr_idx  = up + 1'b1;
                wr_data = upd_pc_i + 30'd1;
            end else if (upd_br_type_i == BR_RETURN) begin
                ptr_d = (upd_cnt_i != '0) ? up - 1'b1 : up;
                cnt_d = (upd_cnt_i != '0) ? upd_cnt_i - 1'b1 : '0;
            end else begin
                ptr_d = up;
                cnt_d = upd_cnt_i;
            end
        end else if (pred_push_i && pred_pop_i) begin
            wr_en  = 1'b1;
            wr_idx = ptr_q;
            cnt_d  = (cnt_q == '0) ? PW'(1) : cnt_q;
        end else if (pred_push_i) begin
            wr_en = 1'b1;
            ptr_d = ptr_q + 1'b1;
            cnt_d = (cnt_q >= FULL) ? FULL : cnt_q + 1'b1;
        end else if (pred_pop_i && cnt_q != '0) begin
            ptr_d = ptr_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            if (wr_en) mem_q[wr_idx] <= wr_data;
        end
    end

    assign ras_top_o   = mem_q[ptr_q];
    assign ras_ptr_o   = {{(PW-IW){1'b0}}, ptr_q};
    assign ras_cnt_o   = cnt_q;
    assign ras_valid_o = (cnt_q != '0);
endmodule

// File: doc/ras_spec_unit.md
RAS_SPEC_UNIT -- requirements
Module: ras_spec_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of return-address entries; a power of two, at least 2.
REQ-002 SHALL have parameter PW, default 5: pointer width, equal to log2(DEPTH)+2 bits of headroom, with only the low log2(DEPTH) bits used for indexing; the count width is PW bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port pred_push_i, input, 1 bit: the fetch-side predictor predicted a call this cycle.
REQ-006 SHALL have port pred_pop_i, input, 1 bit: the fetch-side predictor predicted a return this cycle.
REQ-007 SHALL have port pred_ret_addr_i, input, 30 bits: the word address (pc[31:2]) pushed on pred_push_i.
REQ-008 SHALL have port ras_top_o, output, 30 bits: the predicted return target (word address).
REQ-009 SHALL have port ras_ptr_o, output, PW bits: the current top pointer; the predictor carries it as the branch checkpoint.
REQ-010 SHALL have port ras_cnt_o, output, PW bits: the number of valid entries, from 0 to DEPTH; also carried as the checkpoint.
REQ-011 SHALL have port ras_valid_o, output, 1 bit: ras_cnt_o is nonzero.
REQ-012 SHALL have port upd_valid_i, input, 1 bit: the branch-feedback update from the execute stage is valid.
REQ-013 SHALL have port upd_flush_i, input, 1 bit: the feedback stage detected a mispredict (update.flush).
REQ-014 SHALL have port upd_br_type_i, input, 2 bits: the resolved branch type, using the `_CALL / `_RETURN / `_ABSOLUTE / `_PC_RELATIVE codes from bpu.svh.
REQ-015 SHALL have port upd_pc_i, input, 30 bits: the resolved branch pc[31:2].
REQ-016 SHALL have port upd_ptr_i, input, PW bits: the checkpointed ras_ptr_o for that branch, sampled before its own speculative push or pop.
REQ-017 SHALL have port upd_cnt_i, input, PW bits: the checkpointed ras_cnt_o for that branch.

Function
REQ-018 SHALL hold DEPTH x 30-bit entries as a circular buffer indexed by ptr mod DEPTH; ras_top_o SHALL equal entry[ptr mod DEPTH] combinationally.
REQ-019 Push only: ptr <= ptr+1 (wrapping mod DEPTH), entry[ptr+1] <= pred_ret_addr_i, cnt <= min(cnt+1, DEPTH); at full, the oldest entry is silently overwritten.
REQ-020 Pop only: if cnt>0, ptr <= ptr-1 (wrapping) and cnt <= cnt-1; if cnt==0, ptr and cnt are unchanged.
REQ-021 Push and pop in the same cycle: entry[ptr] <= pred_ret_addr_i, ptr is unchanged, cnt <= max(cnt,1).
REQ-022 Latency: a push or pop becomes visible on ras_top_o, ras_ptr_o and ras_cnt_o one cycle later; there is no same-cycle bypass.
REQ-023 Repair SHALL occur when upd_valid_i and upd_flush_i are both 1; in that cycle the pred_push_i and pred_pop_i inputs are ignored.
REQ-024 Repair for `_CALL: ptr <= upd_ptr_i+1, entry[upd_ptr_i+1] <= upd_pc_i+1 (30-bit wrap), cnt <= min(upd_cnt_i+1, DEPTH).
REQ-025 Repair for `_RETURN: if upd_cnt_i>0, ptr <= upd_ptr_i-1 and cnt <= upd_cnt_i-1; otherwise ptr <= upd_ptr_i and cnt <= 0.
REQ-026 Repair for any other type: ptr <= upd_ptr_i and cnt <= upd_cnt_i.
REQ-027 Repair SHALL NOT modify any entry other than the single write in REQ-024; entries above the restored pointer keep stale data.
REQ-028 When upd_valid_i=1 and upd_flush_i=0, the block SHALL make no state change; prediction-side operations proceed normally.
REQ-029 All pointer arithmetic SHALL be modulo DEPTH on the index bits; cnt arithmetic SHALL saturate at 0 and at DEPTH.

Reset
REQ-030 While rst=1, at any time including mid-operation, ptr=0, cnt=0 and all entries are 0, so ras_top_o=0, ras_ptr_o=0, ras_cnt_o=0 and ras_valid_o=0.
REQ-031 The first clock edge after rst falls SHALL obey REQ-019 to REQ-026 normally.

Verification
REQ-032 Reset, then push 0x100, 0x200, 0x300 on three cycles -> ras_top_o=0x300, ras_cnt_o=3; two pops -> ras_top_o=0x100, ras_cnt_o=1.
REQ-033 With DEPTH=8, push 0x1 to 0x9 -> ras_cnt_o=8 and ras_top_o=0x9; eight pops return 0x9 down to 0x2; a ninth pop leaves ras_cnt_o=0 and ras_ptr_o unchanged.
REQ-034 Push 0xA0 with pred_push_i and pred_pop_i both 1 when cnt=2 and top=0x50 -> ras_top_o=0xA0, cnt=2, ptr unchanged.
REQ-035 Checkpoint ptr=3, cnt=3; perform three wrong-path pushes; then repair with `_CALL, upd_pc_i=0x400 -> ras_ptr_o=4, ras_top_o=0x401, ras_cnt_o=4, and the same-cycle pred_push_i is ignored.
REQ-036 Repair with `_RETURN, upd_ptr_i=0, upd_cnt_i=0 -> ptr=0, cnt=0, ras_valid_o=0; repair with `_PC_RELATIVE, upd_ptr_i=7, upd_cnt_i=8 -> ptr=7, cnt=8.
REQ-037 Assert rst for one cycle in the middle of a push burst -> all outputs are 0 immediately (asynchronously), and the first push after release lands at ptr=1.
